writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 19 +
 rtl/writeback_unit_load_aligner.sv | 35 +++
 rtl/writeback_unit.sv | 147 ++++++++++++++
 tb/tb_writeback_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared encodings for the writeback unit: result-source selects, load sizes and FSM states.
package writeback_unit_pkg;

   localparam logic [1:0] SEL_MEM = 2'b00;
   localparam logic [1:0] SEL_PC  = 2'b01;
   localparam logic [1:0] SEL_ALU = 2'b10;
   localparam logic [1:0] SEL_IMM = 2'b11;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_WAIT_MEM = 2'b01,
      ST_IRQ      = 2'b10
   } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_aligner.sv
// Combinational load aligner: extracts the addressed byte/halfword/word from a memory
// beat and zero- or sign-extends it to the register width.
module load_aligner
   import writeback_unit_pkg::*;
#(
   parameter int  DATA_W = 32,
   localparam int OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        size_i,
   input  logic              signed_i,
   input  logic [OFF_W-1:0]  off_i,
   output logic [DATA_W-1:0] data_o
);

   logic [OFF_W+2:0] byte_lsb_s;
   logic [OFF_W+2:0] half_lsb_s;
   logic [7:0]       byte_s;
   logic [15:0]      half_s;

   // Select the addressed lane (halfword ignores off[0]) and extend it.
   always_comb begin
      byte_lsb_s = {off_i, 3'b000};
      half_lsb_s = {off_i[OFF_W-1:1], 4'b0000};
      byte_s     = data_i[byte_lsb_s +: 8];
      half_s     = data_i[half_lsb_s +: 16];
      case (size_i)
         LS_BYTE:        data_o = {{(DATA_W-8){signed_i & byte_s[7]}}, byte_s};
         LS_HALF:        data_o = {{(DATA_W-16){signed_i & half_s[15]}}, half_s};
         LS_WORD, 2'b11: data_o = data_i;
         default:        data_o = data_i;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: muxes the result source, waits for load data with a timeout,
// and takes interrupts between instructions. All register-file outputs are registered.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int  DATA_W      = 32,
   parameter int  REG_AW      = 5,
   parameter int  MEM_TIMEOUT = 16,
   localparam int OFF_W       = $clog2(DATA_W / 8)
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Valid,
   output logic              o_Ready,
   input  logic [1:0]        i_RfDataInSel,
   input  logic [DATA_W-1:0] i_AluOut,
   input  logic [DATA_W-1:0] i_Imm22,
   input  logic [DATA_W-1:0] i_ProgramCounter,
   input  logic [REG_AW-1:0] i_DestReg,
   input  logic              i_WriteEn,
   input  logic [1:0]        i_LoadSize,
   input  logic              i_LoadSigned,
   input  logic [OFF_W-1:0]  i_ByteOff,
   input  logic              i_MemValid,
   input  logic [DATA_W-1:0] i_DataMem,
   input  logic              i_InterruptSignal,
   output logic              o_RfWe,
   output logic [REG_AW-1:0] o_RfAddr,
   output logic [DATA_W-1:0] o_RfData,
   output logic              o_BusErr,
   output logic              o_IrqAck
);

   localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

   wb_state_e         state_q;
   logic              pending_q;
   logic              irq_prev_q;
   logic [7:0]        cnt_q;
   logic [REG_AW-1:0] ld_dest_q;
   logic              ld_we_q;
   logic [1:0]        ld_size_q;
   logic              ld_signed_q;
   logic [OFF_W-1:0]  ld_off_q;
   logic              rf_we_q;
   logic [REG_AW-1:0] rf_addr_q;
   logic [DATA_W-1:0] rf_data_q;
   logic              bus_err_q;
   logic              irq_ack_q;

   logic              irq_rise_s;
   logic              irq_take_s;
   logic              accept_s;
   logic [DATA_W-1:0] src_s;
   logic [DATA_W-1:0] aligned_s;

   assign irq_rise_s = i_InterruptSignal & ~irq_prev_q;
   assign irq_take_s = (state_q == ST_IDLE) & pending_q;
   assign o_Ready    = (state_q == ST_IDLE) & ~pending_q;
   assign accept_s   = i_Valid & o_Ready;

   assign o_RfWe   = rf_we_q;
   assign o_RfAddr = rf_addr_q;
   assign o_RfData = rf_data_q;
   assign o_BusErr = bus_err_q;
   assign o_IrqAck = irq_ack_q;

   // Non-memory result source mux.
   always_comb begin
      case (i_RfDataInSel)
         SEL_PC:  src_s = i_ProgramCounter;
         SEL_ALU: src_s = i_AluOut;
         SEL_IMM: src_s = i_Imm22;
         default: src_s = {DATA_W{1'b0}};
      endcase
   end

   load_aligner #(.DATA_W(DATA_W)) u_aligner (
      .data_i   (i_DataMem),
      .size_i   (ld_size_q),
      .signed_i (ld_signed_q),
      .off_i    (ld_off_q),
      .data_o   (aligned_s)
   );

   // Writeback FSM with registered outputs; a new interrupt edge outranks the clear.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         irq_prev_q  <= 1'b0;
         cnt_q       <= 8'd0;
         ld_dest_q   <= {REG_AW{1'b0}};
         ld_we_q     <= 1'b0;
         ld_size_q   <= 2'b00;
         ld_signed_q <= 1'b0;
         ld_off_q    <= {OFF_W{1'b0}};
         rf_we_q     <= 1'b0;
         rf_addr_q   <= {REG_AW{1'b0}};
         rf_data_q   <= {DATA_W{1'b0}};
         bus_err_q   <= 1'b0;
         irq_ack_q   <= 1'b0;
      end else begin
         irq_prev_q <= i_InterruptSignal;
         pending_q  <= irq_rise_s | (pending_q & ~irq_take_s);
         rf_we_q    <= 1'b0;
         bus_err_q  <= 1'b0;
         irq_ack_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (irq_take_s) begin
                  state_q   <= ST_IRQ;
                  irq_ack_q <= 1'b1;
               end else if (accept_s && (i_RfDataInSel == SEL_MEM)) begin
                  state_q     <= ST_WAIT_MEM;
                  cnt_q       <= 8'd0;
                  ld_dest_q   <= i_DestReg;
                  ld_we_q     <= i_WriteEn & (i_DestReg != {REG_AW{1'b0}});
                  ld_size_q   <= i_LoadSize;
                  ld_signed_q <= i_LoadSigned;
                  ld_off_q    <= i_ByteOff;
               end else if (accept_s) begin
                  rf_we_q   <= i_WriteEn & (i_DestReg != {REG_AW{1'b0}});
                  rf_addr_q <= i_DestReg;
                  rf_data_q <= src_s;
               end
            end
            ST_WAIT_MEM: begin
               if (i_MemValid) begin
                  state_q   <= ST_IDLE;
                  rf_we_q   <= ld_we_q;
                  rf_addr_q <= ld_dest_q;
                  rf_data_q <= aligned_s;
               end else if (cnt_q == CNT_LAST) begin
                  state_q   <= ST_IDLE;
                  bus_err_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_IRQ:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized self-checking bench for writeback_unit against a transaction-level reference.
module tb_writeback_unit;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_Valid, o_Ready;
   logic [1:0]    i_RfDataInSel;
   logic [DW-1:0] i_AluOut, i_Imm22, i_ProgramCounter;
   logic [AW-1:0] i_DestReg;
   logic          i_WriteEn;
   logic [1:0]    i_LoadSize;
   logic          i_LoadSigned;
   logic [1:0]    i_ByteOff;
   logic          i_MemValid;
   logic [DW-1:0] i_DataMem;
   logic          i_InterruptSignal;
   logic          o_RfWe;
   logic [AW-1:0] o_RfAddr;
   logic [DW-1:0] o_RfData;
   logic          o_BusErr, o_IrqAck;

   int n_vec = 0;
   int n_err = 0;
   int acks;
   int ready_bad;

   always #5 clk = ~clk;

   writeback_unit #(.DATA_W(DW), .REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
      .i_Clk(clk), .i_Rst(rst_n), .i_Valid(i_Valid), .o_Ready(o_Ready),
      .i_RfDataInSel(i_RfDataInSel), .i_AluOut(i_AluOut), .i_Imm22(i_Imm22),
      .i_ProgramCounter(i_ProgramCounter), .i_DestReg(i_DestReg), .i_WriteEn(i_WriteEn),
      .i_LoadSize(i_LoadSize), .i_LoadSigned(i_LoadSigned), .i_ByteOff(i_ByteOff),
      .i_MemValid(i_MemValid), .i_DataMem(i_DataMem), .i_InterruptSignal(i_InterruptSignal),
      .o_RfWe(o_RfWe), .o_RfAddr(o_RfAddr), .o_RfData(o_RfData),
      .o_BusErr(o_BusErr), .o_IrqAck(o_IrqAck)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference load result from plain shift/mask arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [1:0] sz,
                                            input logic sgn, input logic [1:0] off);
      int          offi;
      logic [31:0] v;
      offi = int'(off);
      if (sz == 2'b00) begin
         v = (d >> (8 * offi)) & 32'h0000_00FF;
         if (sgn && v >= 32'h0000_0080) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
         v = (d >> (16 * (offi / 2))) & 32'h0000_FFFF;
         if (sgn && v >= 32'h0000_8000) v = v | 32'hFFFF_0000;
      end else begin
         v = d;
      end
      return v;
   endfunction

   task automatic wait_ready();
      int k;
      k = 0;
      while (!o_Ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!o_Ready) check_eq("ready_timeout", 32'(o_Ready), 32'd1);
   endtask

   // One transaction; val is the source value (non-memory) or the memory beat (load).
   task automatic apply_op(input logic [1:0] sel, input logic [4:0] dest, input logic we,
                           input logic [1:0] sz, input logic sgn, input logic [1:0] off,
                           input int dly, input logic [31:0] val, input string tag);
      logic [31:0] exp_d;
      logic        exp_we;
      bit          done;
      exp_we = we && (dest != 5'd0);
      wait_ready();
      i_AluOut = $urandom; i_Imm22 = $urandom; i_ProgramCounter = $urandom;
      case (sel)
         2'b01:   i_ProgramCounter = val;
         2'b10:   i_AluOut = val;
         2'b11:   i_Imm22 = val;
         default: i_AluOut = $urandom;
      endcase
      i_Valid = 1'b1; i_RfDataInSel = sel; i_DestReg = dest; i_WriteEn = we;
      i_LoadSize = sz; i_LoadSigned = sgn; i_ByteOff = off;
      @(negedge clk);
      if (sel != 2'b00) begin
         check_eq({tag, "_we"}, 32'(o_RfWe), 32'(exp_we));
         if (exp_we) begin
            check_eq({tag, "_addr"}, 32'(o_RfAddr), 32'(dest));
            check_eq({tag, "_data"}, o_RfData, val);
         end
      end else begin
         exp_d = ref_load(val, sz, sgn, off);
         i_Valid = 1'b0;
         i_DestReg = 5'($urandom); i_LoadSize = 2'($urandom); i_ByteOff = 2'($urandom);
         i_LoadSigned = 1'($urandom);
         check_eq({tag, "_ready_wait"}, 32'(o_Ready), 32'd0);
         check_eq({tag, "_we_wait"}, 32'(o_RfWe), 32'd0);
         done = 1'b0;
         for (int k = 0; k < TMO && !done; k++) begin
            i_MemValid = (k == dly);
            i_DataMem  = (k == dly) ? val : $urandom;
            @(negedge clk);
            i_MemValid = 1'b0;
            if (k == dly) begin
               done = 1'b1;
               check_eq({tag, "_ld_we"}, 32'(o_RfWe), 32'(exp_we));
               check_eq({tag, "_ld_buserr"}, 32'(o_BusErr), 32'd0);
               if (exp_we) begin
                  check_eq({tag, "_ld_addr"}, 32'(o_RfAddr), 32'(dest));
                  check_eq({tag, "_ld_data"}, o_RfData, exp_d);
               end
            end else if (k == TMO - 1) begin
               check_eq({tag, "_to_buserr"}, 32'(o_BusErr), 32'd1);
               check_eq({tag, "_to_we"}, 32'(o_RfWe), 32'd0);
            end
         end
         check_eq({tag, "_ready_back"}, 32'(o_Ready), 32'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [1:0] rsel, rsz, roff;
      logic [4:0] rdest;
      logic       rwe, rsgn;
      int         rdly;
      bit         rb2b;

      rst_n = 1'b0; i_Valid = 1'b0; i_RfDataInSel = 2'b00; i_AluOut = '0; i_Imm22 = '0;
      i_ProgramCounter = '0; i_DestReg = '0; i_WriteEn = 1'b0; i_LoadSize = 2'b00;
      i_LoadSigned = 1'b0; i_ByteOff = 2'b00; i_MemValid = 1'b0; i_DataMem = '0;
      i_InterruptSignal = 1'b0;
      #1;
      check_eq("rst_we", 32'(o_RfWe), 32'd0);
      check_eq("rst_addr", 32'(o_RfAddr), 32'd0);
      check_eq("rst_data", o_RfData, 32'd0);
      check_eq("rst_buserr", 32'(o_BusErr), 32'd0);
      check_eq("rst_irqack", 32'(o_IrqAck), 32'd0);
      check_eq("rst_ready", 32'(o_Ready), 32'd1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", 32'(o_Ready), 32'd1);

      // Directed cases.
      apply_op(2'b10, 5'd5, 1'b1, 2'b00, 1'b0, 2'b00, 0, 32'h1234_5678, "alu");
      i_Valid = 1'b0; @(negedge clk);
      check_eq("alu_we_single", 32'(o_RfWe), 32'd0);
      apply_op(2'b11, 5'd0, 1'b1, 2'b00, 1'b0, 2'b00, 0, 32'hDEAD_BEEF, "dest0");
      i_Valid = 1'b0; @(negedge clk);
      apply_op(2'b00, 5'd9, 1'b1, 2'b00, 1'b1, 2'b10, 2, 32'h0080_0000, "sbyte");
      apply_op(2'b00, 5'd3, 1'b1, 2'b10, 1'b0, 2'b00, 99, 32'h1111_2222, "tmo");
      @(negedge clk);
      check_eq("tmo_pulse_end", 32'(o_BusErr), 32'd0);
      apply_op(2'b00, 5'd4, 1'b1, 2'b01, 1'b1, 2'b11, TMO - 1, 32'h8001_7FFF, "tmo_edge");

      // Interrupt raised while a load is outstanding.
      wait_ready();
      i_Valid = 1'b1; i_RfDataInSel = 2'b00; i_DestReg = 5'd7; i_WriteEn = 1'b1;
      i_LoadSize = 2'b10; i_LoadSigned = 1'b0; i_ByteOff = 2'b00;
      @(negedge clk);
      i_Valid = 1'b0; i_InterruptSignal = 1'b1;
      @(negedge clk);
      i_InterruptSignal = 1'b0; i_MemValid = 1'b1; i_DataMem = 32'hCAFE_F00D;
      @(negedge clk);
      i_MemValid = 1'b0;
      check_eq("irqld_we", 32'(o_RfWe), 32'd1);
      check_eq("irqld_data", o_RfData, 32'hCAFE_F00D);
      check_eq("irqld_ack_early", 32'(o_IrqAck), 32'd0);
      acks = 0; ready_bad = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (o_IrqAck) begin
            acks++;
            if (o_Ready) ready_bad++;
         end
      end
      check_eq("irqld_ack_count", 32'(acks), 32'd1);
      check_eq("irqld_ready_low", 32'(ready_bad), 32'd0);
      check_eq("irqld_ready_back", 32'(o_Ready), 32'd1);

      // Level interrupt in idle: one acknowledge per rising edge.
      i_InterruptSignal = 1'b1;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (o_IrqAck) acks++;
      end
      i_InterruptSignal = 1'b0;
      check_eq("irq_level_acks", 32'(acks), 32'd1);

      // Reset in the middle of a load.
      apply_op(2'b01, 5'd12, 1'b1, 2'b00, 1'b0, 2'b00, 0, 32'hA5A5_0F0F, "pre_rst");
      i_RfDataInSel = 2'b00; i_LoadSize = 2'b10;
      @(negedge clk);
      i_Valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_we", 32'(o_RfWe), 32'd0);
      check_eq("mid_rst_addr", 32'(o_RfAddr), 32'd0);
      check_eq("mid_rst_data", o_RfData, 32'd0);
      check_eq("mid_rst_ready", 32'(o_Ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1; i_MemValid = 1'b1; i_DataMem = 32'h7777_7777;
      @(negedge clk);
      i_MemValid = 1'b0;
      check_eq("post_rst_no_we", 32'(o_RfWe), 32'd0);
      check_eq("post_rst_ready", 32'(o_Ready), 32'd1);

      // Randomized traffic, with back-to-back non-memory transfers.
      for (int n = 0; n < 80; n++) begin
         rsel  = 2'($urandom_range(0, 3));
         rdest = 5'($urandom);
         rwe   = 1'($urandom);
         rsz   = 2'($urandom);
         rsgn  = 1'($urandom);
         roff  = 2'($urandom);
         rdly  = int'($urandom_range(0, 5));
         rb2b  = 1'($urandom);
         apply_op(rsel, rdest, rwe, rsz, rsgn, roff, rdly, $urandom, $sformatf("rnd%0d", n));
         if (rsel != 2'b00 && !rb2b) begin
            i_Valid = 1'b0;
            @(negedge clk);
            check_eq($sformatf("rnd%0d_idle_we", n), 32'(o_RfWe), 32'd0);
         end
      end
      i_Valid = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
